// File: rtl/il_pattern_checker.sv
// Receive-side checker for the seven-word IL stress pattern: hunts for P0, verifies
// LOCK_WORDS in-sequence words, then flags every mismatching word while locked.
module il_pattern_checker #(
   parameter int WIDTH       = 25,
   parameter int LOCK_WORDS  = 14,
   parameter int LOSS_THRESH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             sticky_err,
   output logic [15:0]      err_count,
   output logic [7:0]       loss_count,
   output logic [1:0]       dbg_state
);

   localparam logic [71:0] P0_72 = 72'haaaaaaaaaaaaaaaaaa;
   localparam logic [71:0] P1_72 = 72'h555555555555555555;
   localparam logic [71:0] P2_72 = 72'h0f0f0f0f0f0f0f0f0f;
   localparam logic [71:0] P3_72 = 72'hf0f0f0f0f0f0f0f0f0;
   localparam logic [71:0] P4_72 = 72'h000000000000000000;
   localparam logic [71:0] P5_72 = 72'hffffffffffffffffff;
   localparam logic [71:0] P6_72 = 72'hf5a0f5a0f5a0f5a0f5;

   localparam logic [7:0] LOCK_N = 8'(LOCK_WORDS);
   localparam logic [3:0] LOSS_N = 4'(LOSS_THRESH);

   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   function automatic logic [WIDTH-1:0] pat(input logic [2:0] i);
      case (i)
         3'd1:    return P1_72[WIDTH-1:0];
         3'd2:    return P2_72[WIDTH-1:0];
         3'd3:    return P3_72[WIDTH-1:0];
         3'd4:    return P4_72[WIDTH-1:0];
         3'd5:    return P5_72[WIDTH-1:0];
         3'd6:    return P6_72[WIDTH-1:0];
         default: return P0_72[WIDTH-1:0];
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rx_q;
   logic [2:0]       idx_q, idx_d, idx_nxt;
   logic [7:0]       match_q, match_d;
   logic [3:0]       miss_q, miss_d;
   logic             locked_q, locked_d;
   logic             pulse_q, pulse_d;
   logic             sticky_q, sticky_d;
   logic [15:0]      err_q, err_d;
   logic [7:0]       loss_q, loss_d;
   logic             hit;

   assign idx_nxt = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
   assign hit     = (rx_q == pat(idx_q));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      match_d  = match_q;
      miss_d   = miss_q;
      pulse_d  = 1'b0;
      sticky_d = sticky_q;
      err_d    = err_q;
      loss_d   = loss_q;
      case (state_q)
         HUNT: begin
            if (rx_q == pat(3'd0)) begin
               idx_d   = 3'd1;
               match_d = 8'd1;
               state_d = VERIFY;
            end
         end
         VERIFY: begin
            if (hit) begin
               match_d = match_q + 8'd1;
               idx_d   = idx_nxt;
               if (match_q + 8'd1 == LOCK_N) begin
                  state_d = LOCKED;
                  miss_d  = 4'd0;
               end
            end else begin
               state_d = HUNT;
            end
         end
         LOCKED: begin
            // Free-running index: a slipped link shows up as errors, never re-aligns.
            idx_d = idx_nxt;
            if (hit) begin
               miss_d = 4'd0;
            end else begin
               pulse_d  = 1'b1;
               sticky_d = 1'b1;
               err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
               miss_d   = miss_q + 4'd1;
               if (miss_q + 4'd1 == LOSS_N) begin
                  state_d = HUNT;
                  loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
               end
            end
         end
         default: state_d = HUNT;
      endcase
      if (clear) begin
         err_d    = 16'd0;
         sticky_d = 1'b0;
         loss_d   = 8'd0;
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_q     <= '0;
         state_q  <= HUNT;
         idx_q    <= 3'd0;
         match_q  <= 8'd0;
         miss_q   <= 4'd0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         err_q    <= 16'd0;
         loss_q   <= 8'd0;
      end else begin
         rx_q     <= rx_data;
         state_q  <= state_d;
         idx_q    <= idx_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         err_q    <= err_d;
         loss_q   <= loss_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = pulse_q;
   assign sticky_err = sticky_q;
   assign err_count  = err_q;
   assign loss_count = loss_q;
   assign dbg_state  = state_q;

endmodule
